valu_round_sequencer: RTL and testbench
=======================================

Name: valu_round_sequencer

Overview:
- Multi-cycle controller that runs a fixed encryption/decryption round schedule for one 64-bit vector block.
- Issues exactly one operation per cycle to the shared combinational vector ALU (add/sub/xor/ror over packed lanes).
- Sits between the vector register file/load path and the ALU. Accepts a block and key over a valid/ready handshake and returns the processed block over valid/ready.

Parameters:
- N, 64, vector width in bits.
- LANE, 8, lane width in bits used by the ALU for rotate; N must be a multiple of LANE.
- ROUNDS, 4, rounds per block, 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input block/key valid.
- in_ready  out  1  sequencer can accept a block.
- in_decrypt  in  1  0 = encrypt schedule, 1 = decrypt schedule; sampled on accept.
- in_data  in  N  plaintext/ciphertext block.
- in_key  in  N  base key.
- in_rot  in  $clog2(LANE)  rotate amount r, 0..LANE-1.
- aluA  out  N  ALU operand 1 (regData1).
- aluB  out  N  ALU operand 2 (regData2).
- aluControl  out  2  00 add, 01 sub, 10 xor, 11 ror.
- aluRes  in  N  combinational ALU result for current aluA/aluB/aluControl.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  N  processed block.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1, out_valid=0, busy=0; out_data, aluA, aluB all 0; aluControl=00; round counter=0.
- Accept happens when in_valid & in_ready on a clock edge. The block latches data into the working register acc and latches key, rot and decrypt. in_ready falls the next cycle.
- Round key: kr = key XOR {N/LANE copies of the 8-bit round index i}, zero-extended into each lane.
- Encrypt rounds run i = 0..ROUNDS-1. Each round takes 3 cycles:
  - S_XOR: acc <= acc ^ kr.
  - S_ADD: acc <= acc + kr, lane-wise.
  - S_ROR: acc <= ror(acc, r), every lane.
- Decrypt rounds run i = ROUNDS-1 down to 0. Each round takes 3 cycles:
  - S_ROR: ror by (LANE-r) mod LANE.
  - S_SUB: acc - kr.
  - S_XOR: acc ^ kr.
- ALU driving:
  - In each op state: aluA=acc; aluB=kr, or the rotate amount replicated into the low bits of every lane; aluControl per the encoding above.
  - acc <= aluRes at the end of that cycle.
  - Outside op states: aluA and aluB hold 0, aluControl=00.
- After the last op, state=DONE: out_valid=1 and out_data=acc. These hold stable until out_ready=1. out_ready sampled while out_valid=0 has no effect.
- DONE & out_ready: out_valid falls, state=IDLE, in_ready=1 on the next cycle. There is no same-cycle accept from DONE.
- Latency: accept edge to out_valid high = 3*ROUNDS + 1 cycles.
- Round counter: increments (encrypt) or decrements (decrypt) only after the third op of a round. Counting stops on reaching the final round, with no wrap past ROUNDS-1 or below 0.
- r=0: the rotate op is still issued (ror by 0 / by LANE mod LANE = 0), so cycle count is unchanged.
- in_valid while busy: ignored, no state change. in_data changes while busy do not affect the computation.
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.
- Arithmetic is lane-wise modulo 2^LANE with no inter-lane carry; this is guaranteed by the ALU, and the sequencer adds nothing.

Test Plan:
- Reset mid-operation: assert rst_n=0 at cycle 5 of a run -> outputs return to reset values asynchronously; after release the next accepted block yields the correct result; no stale out_valid.
- Encrypt ROUNDS=1, r=3, key=0, data=64'h0102030405060708 -> each lane is rotated right by 3 (out_data=64'h20406080A0C0E001); out_valid rises exactly 4 cycles after accept.
- Round trip, ROUNDS=4, key=64'h0F1E2D3C4B5A6978, r=5, random data -> encrypt then decrypt returns the original data. aluControl sequence is 10,00,11 ×4, then 11,01,10 ×4.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, busy=1. Pulse out_ready -> IDLE next cycle.
- in_valid=1 held continuously with changing in_data while busy -> only the first block is processed; the second block is accepted only after out_valid/out_ready completes.
- r=0 and key=all-ones, data=0, ROUNDS=1 -> out_data: 0^FF=FF, FF+FF=FE per lane, ror 0 -> 64'hFEFEFEFEFEFEFEFE.

Source files
------------

// File: rtl/valu_round_sequencer.sv
// Round-schedule controller for one vector block: issues one ALU op per cycle
// (xor/add/ror to encrypt, ror/sub/xor to decrypt) and hands the result back over valid/ready.
module valu_round_sequencer #(
  parameter int N      = 64,
  parameter int LANE   = 8,
  parameter int ROUNDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_decrypt,
  input  logic [N-1:0]            in_data,
  input  logic [N-1:0]            in_key,
  input  logic [$clog2(LANE)-1:0] in_rot,
  output logic [N-1:0]            aluA,
  output logic [N-1:0]            aluB,
  output logic [1:0]              aluControl,
  input  logic [N-1:0]            aluRes,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_data,
  output logic                    busy
);

  localparam int RW = $clog2(LANE);
  localparam int NL = N / LANE;

  typedef enum logic [2:0] {
    IDLE, E_XOR, E_ADD, E_ROR, D_ROR, D_SUB, D_XOR, DONE
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    acc, key_q, kr, rot_enc, rot_dec;
  logic [RW-1:0]   rot_q, rot_inv;
  logic            dec_q, accept, op_active, round_end, last_round;
  logic [3:0]      rnd;
  logic [LANE-1:0] rnd_lane;

  assign accept     = in_valid && (state == IDLE);
  assign round_end  = (state == E_ROR) || (state == D_XOR);
  assign last_round = dec_q ? (rnd == 4'd0) : (rnd == 4'(ROUNDS - 1));

  // Round key and rotate operands; the decrypt rotate undoes the encrypt one.
  assign rnd_lane = LANE'(rnd);
  assign kr       = key_q ^ {NL{rnd_lane}};
  assign rot_inv  = RW'(LANE - int'(rot_q));
  assign rot_enc  = {NL{LANE'(rot_q)}};
  assign rot_dec  = {NL{LANE'(rot_inv)}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      key_q <= '0;
      rot_q <= '0;
      dec_q <= 1'b0;
      rnd   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc   <= in_data;
        key_q <= in_key;
        rot_q <= in_rot;
        dec_q <= in_decrypt;
        rnd   <= in_decrypt ? 4'(ROUNDS - 1) : 4'd0;
      end else begin
        if (op_active) acc <= aluRes;
        // The counter parks on the final round instead of wrapping.
        if (round_end && !last_round) rnd <= dec_q ? rnd - 4'd1 : rnd + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    aluA       = '0;
    aluB       = '0;
    aluControl = 2'b00;
    op_active  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = in_decrypt ? D_ROR : E_XOR;
      E_XOR: begin
        op_active = 1'b1; aluA = acc; aluB = kr; aluControl = 2'b10;
        state_nxt = E_ADD;
      end
      E_ADD: begin
        op_active = 1'b1; aluA = acc; aluB = kr; aluControl = 2'b00;
        state_nxt = E_ROR;
      end
      E_ROR: begin
        op_active = 1'b1; aluA = acc; aluB = rot_enc; aluControl = 2'b11;
        state_nxt = last_round ? DONE : E_XOR;
      end
      D_ROR: begin
        op_active = 1'b1; aluA = acc; aluB = rot_dec; aluControl = 2'b11;
        state_nxt = D_SUB;
      end
      D_SUB: begin
        op_active = 1'b1; aluA = acc; aluB = kr; aluControl = 2'b01;
        state_nxt = D_XOR;
      end
      D_XOR: begin
        op_active = 1'b1; aluA = acc; aluB = kr; aluControl = 2'b10;
        state_nxt = last_round ? DONE : D_ROR;
      end
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_valu_round_sequencer.sv
// Bench for valu_round_sequencer: two instances (4 rounds and 1 round) each driven
// by a lane-wise ALU model, with results checked against a per-lane integer cipher model.
module tb_valu_round_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid [2];
  logic       in_ready [2];
  logic       in_decrypt [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       busy [2];
  logic [63:0] in_data [2];
  logic [63:0] in_key [2];
  logic [63:0] aluA [2];
  logic [63:0] aluB [2];
  logic [63:0] aluRes [2];
  logic [63:0] out_data [2];
  logic [2:0]  in_rot [2];
  logic [1:0]  aluControl [2];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  valu_round_sequencer #(.N(64), .LANE(8), .ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_decrypt(in_decrypt[0]), .in_data(in_data[0]), .in_key(in_key[0]), .in_rot(in_rot[0]),
    .aluA(aluA[0]), .aluB(aluB[0]), .aluControl(aluControl[0]), .aluRes(aluRes[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

  valu_round_sequencer #(.N(64), .LANE(8), .ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_decrypt(in_decrypt[1]), .in_data(in_data[1]), .in_key(in_key[1]), .in_rot(in_rot[1]),
    .aluA(aluA[1]), .aluB(aluB[1]), .aluControl(aluControl[1]), .aluRes(aluRes[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  // Shared combinational vector ALU: per-lane add/sub/xor/ror, rotate amount from each lane of b.
  function automatic logic [63:0] alu(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    logic [63:0] r;
    logic [7:0]  x, y;
    logic [15:0] w;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      x = a[8*l +: 8];
      y = b[8*l +: 8];
      w = {x, x};
      case (op)
        2'b00:   r[8*l +: 8] = x + y;
        2'b01:   r[8*l +: 8] = x - y;
        2'b10:   r[8*l +: 8] = x ^ y;
        default: r[8*l +: 8] = w[y[2:0] +: 8];
      endcase
    end
    return r;
  endfunction

  assign aluRes[0] = alu(aluA[0], aluB[0], aluControl[0]);
  assign aluRes[1] = alu(aluA[1], aluB[1], aluControl[1]);

  // Whole-block cipher computed lane by lane with plain integer arithmetic.
  function automatic logic [63:0] refModel(input logic [63:0] d, input logic [63:0] k,
                                           input int r, input int rounds, input bit dec);
    logic [63:0] res;
    int b, kb, kr, rr;
    res = '0;
    rr  = (8 - r) % 8;
    for (int l = 0; l < 8; l++) begin
      b  = int'(d[8*l +: 8]);
      kb = int'(k[8*l +: 8]);
      if (!dec) begin
        for (int i = 0; i < rounds; i++) begin
          kr = kb ^ i;
          b  = b ^ kr;
          b  = (b + kr) % 256;
          b  = ((b >> r) | (b << (8 - r))) & 255;
        end
      end else begin
        for (int i = rounds - 1; i >= 0; i--) begin
          kr = kb ^ i;
          b  = ((b >> rr) | (b << (8 - rr))) & 255;
          b  = (b - kr + 256) % 256;
          b  = b ^ kr;
        end
      end
      res[8*l +: 8] = 8'(b);
    end
    return res;
  endfunction

  function automatic logic [1:0] expCtl(input bit dec, input int step);
    case (step % 3)
      0:       return dec ? 2'b11 : 2'b10;
      1:       return dec ? 2'b01 : 2'b00;
      default: return dec ? 2'b10 : 2'b11;
    endcase
  endfunction

  function automatic logic [63:0] expB(input bit dec, input int rounds, input int step,
                                       input logic [63:0] k, input logic [2:0] r);
    int j, rnd;
    logic [7:0] lane;
    j   = step % 3;
    rnd = dec ? rounds - 1 - step / 3 : step / 3;
    if ((!dec && j == 2) || (dec && j == 0)) begin
      lane = dec ? 8'((8 - int'(r)) % 8) : 8'(r);
      return {8{lane}};
    end
    return k ^ {8{8'(rnd)}};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one block through instance sel, checking every op cycle, latency, hold and handshake.
  task automatic applyStimulus(input int sel, input bit dec, input logic [63:0] d,
                               input logic [63:0] k, input logic [2:0] r, input int hold,
                               input bit keepValid, output logic [63:0] got);
    int rounds, lat, step, guard;
    logic [63:0] exp;
    rounds = (sel == 0) ? 4 : 1;
    exp    = refModel(d, k, int'(r), rounds, dec);
    guard  = 0;
    while (!in_ready[sel] && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    checkOutput("ready_wait", 64'(in_ready[sel]), 64'(1));
    in_valid[sel] = 1'b1; in_decrypt[sel] = dec; in_data[sel] = d; in_key[sel] = k; in_rot[sel] = r;
    @(posedge clk); #1;
    if (!keepValid) in_valid[sel] = 1'b0;
    lat = 1; step = 0;
    while (!out_valid[sel] && lat < 200) begin
      checkOutput("aluControl", 64'(aluControl[sel]), 64'(expCtl(dec, step)));
      checkOutput("aluB", aluB[sel], expB(dec, rounds, step, k, r));
      step++;
      if (keepValid) in_data[sel] = {$urandom, $urandom};
      @(posedge clk); #1; lat++;
    end
    checkOutput("latency", 64'(lat), 64'(3 * rounds + 1));
    checkOutput("out_data", out_data[sel], exp);
    checkOutput("done_alu_idle", 64'(aluControl[sel]), 64'(0));
    got = out_data[sel];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_data", out_data[sel], exp);
      checkOutput("hold_valid", 64'(out_valid[sel]), 64'(1));
      checkOutput("hold_in_ready", 64'(in_ready[sel]), 64'(0));
      checkOutput("hold_busy", 64'(busy[sel]), 64'(1));
    end
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready[sel] = 1'b0;
    checkOutput("release_valid", 64'(out_valid[sel]), 64'(0));
    checkOutput("release_in_ready", 64'(in_ready[sel]), 64'(1));
    checkOutput("release_busy", 64'(busy[sel]), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] got, enc, orig, key;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; in_decrypt[s] = 1'b0; in_data[s] = '0; in_key[s] = '0;
      in_rot[s] = '0; out_ready[s] = 1'b0;
    end
    #12;
    for (int s = 0; s < 2; s++) begin
      checkOutput("rst_in_ready", 64'(in_ready[s]), 64'(1));
      checkOutput("rst_out_valid", 64'(out_valid[s]), 64'(0));
      checkOutput("rst_busy", 64'(busy[s]), 64'(0));
      checkOutput("rst_out_data", out_data[s], 64'(0));
      checkOutput("rst_aluA", aluA[s], 64'(0));
      checkOutput("rst_aluB", aluB[s], 64'(0));
      checkOutput("rst_aluControl", 64'(aluControl[s]), 64'(0));
    end
    @(negedge clk); rst_n = 1'b1;

    // Single round, zero key: pure per-lane rotate by 3.
    applyStimulus(1, 1'b0, 64'h0102030405060708, 64'h0, 3'd3, 0, 1'b0, got);
    checkOutput("ror3_const", got, 64'h20406080A0C0E001);

    // Single round, r=0, all-ones key on zero data.
    applyStimulus(1, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 0, 1'b0, got);
    checkOutput("r0_const", got, 64'hFEFEFEFEFEFEFEFE);

    // Four-round round trip with backpressure on the encrypt result.
    key  = 64'h0F1E2D3C4B5A6978;
    orig = {$urandom, $urandom};
    applyStimulus(0, 1'b0, orig, key, 3'd5, 10, 1'b0, enc);
    applyStimulus(0, 1'b1, enc, key, 3'd5, 0, 1'b0, got);
    checkOutput("roundtrip", got, orig);

    // in_valid held high with churning data while busy.
    orig = {$urandom, $urandom};
    applyStimulus(0, 1'b0, orig, key, 3'd2, 2, 1'b1, got);
    orig = {$urandom, $urandom};
    applyStimulus(0, 1'b1, orig, key, 3'd6, 0, 1'b0, got);

    // Reset in the middle of a run.
    in_valid[0] = 1'b1; in_decrypt[0] = 1'b0; in_data[0] = {$urandom, $urandom};
    in_key[0] = {$urandom, $urandom}; in_rot[0] = 3'd4;
    @(posedge clk); #1; in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy[0]), 64'(0));
    checkOutput("midrst_in_ready", 64'(in_ready[0]), 64'(1));
    checkOutput("midrst_out_valid", 64'(out_valid[0]), 64'(0));
    checkOutput("midrst_aluA", aluA[0], 64'(0));
    checkOutput("midrst_aluControl", 64'(aluControl[0]), 64'(0));
    checkOutput("midrst_out_data", out_data[0], 64'(0));
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_valid", 64'(out_valid[0]), 64'(0));
    end
    applyStimulus(0, 1'b0, 64'h0011223344556677, 64'hA5A5A5A5A5A5A5A5, 3'd1, 0, 1'b0, got);

    // Random blocks on both instances, both directions.
    for (int it = 0; it < 8; it++) begin
      applyStimulus(it % 2, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                    3'($urandom_range(0, 7)), it % 3, 1'b0, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
